// File: rtl/alu_exec_unit.sv
// ALU decode-plus-execute: ADD/SUB/AND/OR/XOR/SLT/illegal in one cycle, MUL via iterative shift-add.
// Latency: 1 cycle for single-cycle ops, WIDTH cycles for MUL (out_valid registered at accept edge + WIDTH).
// Backpressure: in_ready drops for the whole MUL; no output backpressure, out_valid is a one-cycle pulse.
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       alu_function,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             illegal
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_MUL = 3'd2,
        OP_AND = 3'd3,
        OP_OR  = 3'd4,
        OP_XOR = 3'd5,
        OP_SLT = 3'd6,
        OP_ILL = 3'd7
    } op_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             overflow_q, overflow_d;
    logic             illegal_q, illegal_d;

    op_t              op_sel;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             slt;
    logic [WIDTH-1:0] sc_result;
    logic             sc_ovf;
    logic [WIDTH-1:0] acc_step;

    assign sum      = src_a + src_b;
    assign diff     = src_a - src_b;
    assign slt      = $signed(src_a) < $signed(src_b);
    // One shift-add step: add the multiplicand when the current multiplier bit is set.
    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

    // Decode alu_op / alu_function into one operation; every unlisted combination is illegal.
    always_comb begin
        op_sel = OP_ILL;
        case (alu_op)
            2'b00: op_sel = OP_ADD;
            2'b01: op_sel = OP_SUB;
            2'b10: begin
                case (alu_function)
                    6'b000000: op_sel = OP_ADD;
                    6'b000001: op_sel = OP_SUB;
                    6'b000010: op_sel = OP_MUL;
                    6'b000011: op_sel = OP_AND;
                    6'b000100: op_sel = OP_OR;
                    6'b000101: op_sel = OP_XOR;
                    6'b000110: op_sel = OP_SLT;
                    default:   op_sel = OP_ILL;
                endcase
            end
            default: op_sel = OP_ILL;
        endcase
    end

    // Single-cycle datapath; MUL and illegal produce 0 here (MUL result comes from the engine).
    always_comb begin
        sc_result = '0;
        sc_ovf    = 1'b0;
        case (op_sel)
            OP_ADD: begin
                sc_result = sum;
                sc_ovf    = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (sum[WIDTH-1] != src_a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_result = diff;
                sc_ovf    = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (diff[WIDTH-1] != src_a[WIDTH-1]);
            end
            OP_AND:  sc_result = src_a & src_b;
            OP_OR:   sc_result = src_a | src_b;
            OP_XOR:  sc_result = src_a ^ src_b;
            OP_SLT:  sc_result = {{(WIDTH-1){1'b0}}, slt};
            default: sc_result = '0;
        endcase
    end

    // Next-state and output-register logic for the IDLE/MUL controller.
    always_comb begin
        state_d     = state_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = 1'b0;
        result_d    = result_q;
        zero_d      = zero_q;
        overflow_d  = overflow_q;
        illegal_d   = illegal_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (op_sel == OP_MUL) begin
                        mcand_d  = src_a;
                        mplier_d = src_b;
                        acc_d    = '0;
                        cnt_d    = CW'(WIDTH);
                        state_d  = S_MUL;
                    end else begin
                        out_valid_d = 1'b1;
                        result_d    = sc_result;
                        zero_d      = (sc_result == '0);
                        overflow_d  = sc_ovf;
                        illegal_d   = (op_sel == OP_ILL);
                    end
                end
            end
            S_MUL: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    out_valid_d = 1'b1;
                    result_d    = acc_step;
                    zero_d      = (acc_step == '0);
                    overflow_d  = 1'b0;
                    illegal_d   = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset aborts any MUL in flight and clears all outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            overflow_q  <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            overflow_q  <= overflow_d;
            illegal_q   <= illegal_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign overflow  = overflow_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit (WIDTH = 32): table of single-cycle vectors streamed back-to-back,
// hand-written MUL sequences with latency/handshake checks, and reset abort during MUL.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_alu_exec_unit;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   alu_op;
    logic [5:0]   alu_function;
    logic [W-1:0] src_a;
    logic [W-1:0] src_b;
    logic         out_valid;
    logic [W-1:0] result;
    logic         zero;
    logic         overflow;
    logic         illegal;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [1:0]   op;
        logic [5:0]   fn;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
        logic         z;
        logic         ov;
        logic         ill;
    } vec_t;

    localparam int NV = 16;
    vec_t vt[NV];

    alu_exec_unit #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .alu_op       (alu_op),
        .alu_function (alu_function),
        .src_a        (src_a),
        .src_b        (src_b),
        .out_valid    (out_valid),
        .result       (result),
        .zero         (zero),
        .overflow     (overflow),
        .illegal      (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input int i);
        alu_op       = vt[i].op;
        alu_function = vt[i].fn;
        src_a        = vt[i].a;
        src_b        = vt[i].b;
    endtask

    task automatic check_vec(input int i);
        chk($sformatf("v%0d.out_valid", i), {31'd0, out_valid}, 32'd1);
        chk($sformatf("v%0d.result", i),    result,             vt[i].r);
        chk($sformatf("v%0d.zero", i),      {31'd0, zero},      {31'd0, vt[i].z});
        chk($sformatf("v%0d.overflow", i),  {31'd0, overflow},  {31'd0, vt[i].ov});
        chk($sformatf("v%0d.illegal", i),   {31'd0, illegal},   {31'd0, vt[i].ill});
        chk($sformatf("v%0d.in_ready", i),  {31'd0, in_ready},  32'd1);
    endtask

    // MUL with the request held high until the completion pulse is seen.
    task automatic do_mul(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp);
        int busy;
        int pulses;
        bit got;
        busy   = 0;
        pulses = 0;
        got    = 1'b0;
        alu_op       = 2'b10;
        alu_function = 6'b000010;
        src_a        = a;
        src_b        = b;
        in_valid     = 1'b1;
        @(posedge clk);
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clk);
            if (out_valid) begin
                got = 1'b1;
                pulses++;
                in_valid = 1'b0;
                chk({nm, ".result"},   result,             exp);
                chk({nm, ".zero"},     {31'd0, zero},      {31'd0, (exp == '0)});
                chk({nm, ".overflow"}, {31'd0, overflow},  32'd0);
                chk({nm, ".illegal"},  {31'd0, illegal},   32'd0);
                chk({nm, ".ready_at_done"}, {31'd0, in_ready}, 32'd1);
            end else if (!in_ready) begin
                busy++;
            end
        end
        in_valid = 1'b0;
        chk({nm, ".completed"}, {31'd0, got}, 32'd1);
        chk({nm, ".busy_cycles"}, busy, W);
        repeat (4) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        chk({nm, ".pulses"}, pulses, 32'd1);
    endtask

    initial begin
        //        op     fn         a              b              r              z     ov    ill
        vt[0]  = '{2'b10, 6'b000000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0};
        vt[1]  = '{2'b01, 6'b000000, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b0};
        vt[2]  = '{2'b10, 6'b000110, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0};
        vt[3]  = '{2'b10, 6'b000011, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0};
        vt[4]  = '{2'b10, 6'b000100, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1'b0, 1'b0};
        vt[5]  = '{2'b10, 6'b000101, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0, 1'b0};
        vt[6]  = '{2'b10, 6'b111111, 32'h00000123, 32'h00000456, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vt[7]  = '{2'b11, 6'b000000, 32'h00000001, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vt[8]  = '{2'b00, 6'b000000, 32'h00000002, 32'h00000003, 32'h00000005, 1'b0, 1'b0, 1'b0};
        vt[9]  = '{2'b10, 6'b000001, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0};
        vt[10] = '{2'b00, 6'b111111, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0};
        vt[11] = '{2'b10, 6'b000111, 32'h00000009, 32'h00000009, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vt[12] = '{2'b11, 6'b000010, 32'h00000007, 32'h00000006, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vt[13] = '{2'b10, 6'b000110, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b0};
        vt[14] = '{2'b10, 6'b000001, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
        vt[15] = '{2'b00, 6'b000000, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1, 1'b0};

        rst_n        = 1'b0;
        in_valid     = 1'b0;
        alu_op       = 2'b00;
        alu_function = 6'b000000;
        src_a        = '0;
        src_b        = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset.out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset.result",    result,             32'd0);
        chk("reset.zero",      {31'd0, zero},      32'd0);
        chk("reset.overflow",  {31'd0, overflow},  32'd0);
        chk("reset.illegal",   {31'd0, illegal},   32'd0);
        chk("reset.in_ready",  {31'd0, in_ready},  32'd1);

        // Release and stream every table vector back-to-back: one result per cycle.
        rst_n = 1'b1;
        drive(0);
        in_valid = 1'b1;
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            check_vec(i);
            if (i < NV - 1) drive(i + 1);
            else in_valid = 1'b0;
        end
        @(negedge clk);
        chk("stream.idle_no_valid", {31'd0, out_valid}, 32'd0);

        do_mul("mul_ffxff", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);
        do_mul("mul_by0",   32'h00003039, 32'h00000000, 32'h00000000);
        do_mul("mul_shift", 32'h00010000, 32'h00010000, 32'h00000000);
        do_mul("mul_7x6",   32'h00000007, 32'h00000006, 32'd42);

        // Reset during MUL: abort at once, no completion afterwards.
        alu_op       = 2'b10;
        alu_function = 6'b000010;
        src_a        = 32'd7;
        src_b        = 32'd6;
        in_valid     = 1'b1;
        @(posedge clk);
        repeat (10) @(negedge clk);
        chk("abort.busy_before", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("abort.out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort.result",    result,             32'd0);
        chk("abort.zero",      {31'd0, zero},      32'd0);
        chk("abort.in_ready",  {31'd0, in_ready},  32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        drive(8);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check_vec(8);
        begin
            int late;
            late = 0;
            repeat (W + 4) begin
                @(negedge clk);
                if (out_valid) late++;
            end
            chk("abort.no_late_valid", late, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
